// File: rtl/softcore_irq_aggregator_if.sv
// softcore_irq_aggregator_if: Avalon-MM slave bus between the CPU and the irq aggregator
interface softcore_irq_aggregator_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );
   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/softcore_irq_aggregator.sv
// softcore_irq_aggregator: latches/mirrors peripheral irqs, masks them and drives one registered irq to the CPU
module softcore_irq_aggregator #(
   parameter int NUM_SRC = 8,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
   input  logic clk,
   input  logic reset_n,
   softcore_irq_aggregator_if.slave avs,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic irq_out
);
   logic [NUM_SRC-1:0] pending, enable, irq_prev, rise, masked, w1c, pending_nxt;
   logic               gie, wr_sel, wr_en, wr_pend, wr_count, wr_ctrl, unused_wd;
   logic [15:0]        event_count, rd_mux;
   logic [16:0]        count_sum;
   logic [4:0]         n_rise;
   logic [3:0]         id;
   assign wr_sel    = avs.chipselect && !avs.write_n;
   assign wr_en     = wr_sel && avs.address == 3'd1;
   assign wr_pend   = wr_sel && avs.address == 3'd2;
   assign wr_count  = wr_sel && avs.address == 3'd4;
   assign wr_ctrl   = wr_sel && avs.address == 3'd5;
   assign unused_wd = ^avs.writedata;
   always_comb begin
      rise        = irq_in & ~irq_prev & EDGE_MASK;
      masked      = pending & enable;
      w1c         = wr_pend ? avs.writedata[NUM_SRC-1:0] : '0;
      // a rise in the same cycle as a clear wins, so no edge is ever lost
      pending_nxt = (EDGE_MASK & ((pending & ~w1c) | rise)) | (~EDGE_MASK & irq_in);
      n_rise      = '0;
      for (int i = 0; i < NUM_SRC; i++) n_rise = n_rise + 5'(rise[i]);
      id          = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (masked[i]) id = 4'(i);
      count_sum   = {1'b0, event_count} + 17'(n_rise);
      rd_mux      = avs.address == 3'd0 ? 16'(masked) | (16'(gie) << NUM_SRC) :
                    avs.address == 3'd1 ? 16'(enable) :
                    avs.address == 3'd2 ? 16'(pending) :
                    avs.address == 3'd3 ? {|masked, 11'b0, id} :
                    avs.address == 3'd4 ? event_count :
                    avs.address == 3'd5 ? {15'b0, gie} : 16'h0000;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_prev     <= '0;
         pending      <= '0;
         enable       <= '0;
         gie          <= 1'b0;
         event_count  <= '0;
         avs.readdata <= '0;
         irq_out      <= 1'b0;
      end else begin
         irq_prev     <= irq_in;
         pending      <= pending_nxt;
         avs.readdata <= rd_mux;
         irq_out      <= gie && |masked;
         if (wr_en) enable <= avs.writedata[NUM_SRC-1:0];
         if (wr_ctrl) gie <= avs.writedata[0];
         event_count  <= wr_count ? '0 : count_sum[16] ? 16'hFFFF : count_sum[15:0];
      end
   end
endmodule

// File: tb/tb_softcore_irq_aggregator.sv
// tb_softcore_irq_aggregator: directed table and sequence checks for the irq aggregator
module tb_softcore_irq_aggregator;
   localparam logic [7:0] EMASK = 8'hF3;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] irq_in = '0;
   logic       irq_out;
   int         n_chk = 0;
   int         n_pass = 0;
   softcore_irq_aggregator_if bus_if();
   softcore_irq_aggregator #(.NUM_SRC(8), .EDGE_MASK(EMASK)) dut (
      .clk(clk), .reset_n(reset_n), .avs(bus_if.slave), .irq_in(irq_in), .irq_out(irq_out)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0]  irq;
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [2:0]  raddr;
      logic [15:0] exp_rd;
      logic        exp_irq;
   } vec_t;
   vec_t vecs[19];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus_if.address = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n = 1'b0;
      bus_if.writedata = d;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write_n = 1'b1;
   endtask
   task automatic rd(input logic [2:0] a);
      bus_if.address = a;
      tick();
   endtask
   task automatic pulse(input logic [7:0] v);
      irq_in = v;
      tick();
      irq_in = '0;
      tick();
   endtask
   initial begin
      vecs[0]  = '{8'h00, 1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0};
      vecs[1]  = '{8'h00, 1'b1, 3'd1, 16'h00FF, 3'd1, 16'h00FF, 1'b0};
      vecs[2]  = '{8'h00, 1'b1, 3'd5, 16'h0001, 3'd0, 16'h0100, 1'b0};
      vecs[3]  = '{8'h04, 1'b0, 3'd0, 16'h0000, 3'd2, 16'h0004, 1'b1};
      vecs[4]  = '{8'h24, 1'b0, 3'd0, 16'h0000, 3'd3, 16'h8002, 1'b1};
      vecs[5]  = '{8'h24, 1'b1, 3'd1, 16'h00FB, 3'd3, 16'h8005, 1'b1};
      vecs[6]  = '{8'h24, 1'b1, 3'd1, 16'h00DB, 3'd3, 16'h0000, 1'b0};
      vecs[7]  = '{8'h24, 1'b0, 3'd0, 16'h0000, 3'd2, 16'h0024, 1'b0};
      vecs[8]  = '{8'h24, 1'b1, 3'd2, 16'h0024, 3'd2, 16'h0004, 1'b0};
      vecs[9]  = '{8'h00, 1'b1, 3'd1, 16'h00FF, 3'd2, 16'h0000, 1'b0};
      vecs[10] = '{8'h03, 1'b0, 3'd0, 16'h0000, 3'd4, 16'h0003, 1'b1};
      vecs[11] = '{8'h03, 1'b1, 3'd0, 16'hFFFF, 3'd0, 16'h0103, 1'b1};
      vecs[12] = '{8'h03, 1'b1, 3'd6, 16'hFFFF, 3'd6, 16'h0000, 1'b1};
      vecs[13] = '{8'h03, 1'b1, 3'd5, 16'h0000, 3'd5, 16'h0000, 1'b0};
      vecs[14] = '{8'h03, 1'b1, 3'd5, 16'h0001, 3'd5, 16'h0001, 1'b1};
      vecs[15] = '{8'h03, 1'b1, 3'd1, 16'hFF00, 3'd1, 16'h0000, 1'b0};
      vecs[16] = '{8'h03, 1'b1, 3'd1, 16'h00FF, 3'd7, 16'h0000, 1'b1};
      vecs[17] = '{8'h03, 1'b1, 3'd2, 16'h0003, 3'd2, 16'h0000, 1'b0};
      vecs[18] = '{8'h00, 1'b1, 3'd4, 16'h1234, 3'd4, 16'h0000, 1'b0};
      bus_if.address = '0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n = 1'b1;
      bus_if.writedata = '0;
      tick();
      tick();
      chk("reset readdata", bus_if.readdata, 16'h0000);
      chk("reset irq_out", 16'(irq_out), 16'h0000);
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 19; i++) begin
         irq_in = vecs[i].irq;
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
         else tick();
         tick();
         rd(vecs[i].raddr);
         chk($sformatf("vec%0d readdata", i), bus_if.readdata, vecs[i].exp_rd);
         chk($sformatf("vec%0d irq_out", i), 16'(irq_out), 16'(vecs[i].exp_irq));
      end
      // edge source 0: pending one cycle after the pulse, irq_out the cycle after that
      bus_if.address = 3'd2;
      irq_in = 8'h01;
      tick();
      chk("edge irq_out early", 16'(irq_out), 16'h0000);
      irq_in = 8'h00;
      tick();
      chk("edge pending", bus_if.readdata, 16'h0001);
      chk("edge irq_out", 16'(irq_out), 16'h0001);
      wr(3'd2, 16'h0001);
      tick();
      chk("edge w1c irq_out", 16'(irq_out), 16'h0000);
      chk("edge w1c pending", bus_if.readdata, 16'h0000);
      // level source 3 ignores W1C and follows its input
      irq_in = 8'h08;
      tick();
      tick();
      chk("level irq_out", 16'(irq_out), 16'h0001);
      wr(3'd2, 16'h0008);
      tick();
      chk("level w1c ignored", bus_if.readdata, 16'h0008);
      irq_in = 8'h00;
      tick();
      chk("level irq_out hold", 16'(irq_out), 16'h0001);
      tick();
      chk("level drop irq_out", 16'(irq_out), 16'h0000);
      chk("level drop pending", bus_if.readdata, 16'h0000);
      // rise together with W1C keeps the bit set
      bus_if.chipselect = 1'b1;
      bus_if.write_n = 1'b0;
      bus_if.writedata = 16'h0001;
      irq_in = 8'h01;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write_n = 1'b1;
      tick();
      chk("rise beats w1c", bus_if.readdata, 16'h0001);
      irq_in = 8'h00;
      wr(3'd2, 16'h0001);
      tick();
      // COUNT write in the same cycle as rises drops those rises
      bus_if.address = 3'd4;
      bus_if.chipselect = 1'b1;
      bus_if.write_n = 1'b0;
      irq_in = 8'h03;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write_n = 1'b1;
      irq_in = 8'h00;
      rd(3'd4);
      chk("count clear wins", bus_if.readdata, 16'h0000);
      wr(3'd2, 16'h00FF);
      tick();
      // COUNT saturation: 10922 x 6 rises = 65532, then 2 more, then 3 more
      wr(3'd4, 16'h0000);
      for (int i = 0; i < 10922; i++) pulse(8'hF3);
      pulse(8'h01);
      pulse(8'h01);
      rd(3'd4);
      chk("count fffe", bus_if.readdata, 16'hFFFE);
      pulse(8'h13);
      rd(3'd4);
      chk("count saturate", bus_if.readdata, 16'hFFFF);
      wr(3'd4, 16'h5555);
      rd(3'd4);
      chk("count write clear", bus_if.readdata, 16'h0000);
      // async reset while irq_out=1 and COUNT=7
      pulse(8'h13);
      pulse(8'h13);
      pulse(8'h01);
      rd(3'd4);
      chk("count seven", bus_if.readdata, 16'h0007);
      chk("pre-reset irq_out", 16'(irq_out), 16'h0001);
      reset_n = 1'b0;
      #2;
      chk("async irq_out", 16'(irq_out), 16'h0000);
      chk("async readdata", bus_if.readdata, 16'h0000);
      tick();
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a));
         chk($sformatf("post-reset reg%0d", a), bus_if.readdata, 16'h0000);
      end
      chk("post-reset irq_out", 16'(irq_out), 16'h0000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
